// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run controller: state encoding and internal counter width.
package core_run_ctrl_pkg;

  localparam int unsigned StateW = 3;
  // Wide enough for any sensible reset-hold or wake-settle length.
  localparam int unsigned CntW   = 16;

  // Encodings are visible on ctrl_state, so the values are fixed.
  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StRstHold = 3'd1,
    StRun     = 3'd2,
    StSleep   = 3'd3,
    StWake    = 3'd4,
    StHalt    = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/core_irq_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt level.
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset, clears every stage
//   irq_raw_i  - asynchronous interrupt level
//   irq_sync_o - synchronized level, Stages cycles behind irq_raw_i
module core_irq_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_raw_i,
  output logic irq_sync_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], irq_raw_i};
    end
  end

  assign irq_sync_o = sync_q[Stages-1];

endmodule

// File: rtl/core_run_ctrl.sv
// Boot / sleep / error lifecycle sequencer sitting between the SoC top and core_top.
// Holds the core in reset while booting, selects pc_init_use, gates the core clock during
// WFI, wakes the core on a synchronized external interrupt and parks it on an unexpected error.
// Optional watchdog: define CORE_WDT_EN to build the RUN-state watchdog counter; otherwise
// wdt_kick is ignored and wdt_expired stays 0.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   boot_req, pc_init_sel   - boot request (IDLE only) and pc_init_use value captured on boot
//   ext_irq_raw, irq_mask   - asynchronous interrupt level and its mask
//   core_wfi, core_unexcp_err, err_clear, wdt_kick - core status and control inputs
//   core_rst_n, core_pc_init_use, core_ext_irq, core_clk_en - registered core controls
//   ctrl_state, err_count, wdt_expired - registered status
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int unsigned     RST_HOLD_CYC    = 8,
  parameter int unsigned     WAKE_SETTLE_CYC = 2,
  parameter int unsigned     IRQ_SYNC_STAGES = 2,
  parameter int unsigned     ERR_CNT_W       = 8,
  parameter int unsigned     WDT_W           = 16,
  parameter logic [WDT_W-1:0] WDT_LIMIT      = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_req,
  input  logic                 pc_init_sel,
  input  logic                 ext_irq_raw,
  input  logic                 irq_mask,
  input  logic                 core_wfi,
  input  logic                 core_unexcp_err,
  input  logic                 err_clear,
  input  logic                 wdt_kick,
  output logic                 core_rst_n,
  output logic                 core_pc_init_use,
  output logic                 core_ext_irq,
  output logic                 core_clk_en,
  output logic [StateW-1:0]    ctrl_state,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wdt_expired
);

  ctrl_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pc_sel_q, pc_sel_d;
  logic                 rst_n_q, rst_n_d;
  logic                 clk_en_q, clk_en_d;
  logic                 ext_irq_q, ext_irq_d;
  logic                 expired_q, expired_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 irq_sync;
  logic                 irq_lvl;
  logic                 wdt_fire;

  core_irq_sync #(
    .Stages (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_raw_i  (ext_irq_raw),
    .irq_sync_o (irq_sync)
  );

  assign irq_lvl = irq_sync & ~irq_mask;

`ifdef CORE_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Fires on the RUN cycle whose increment would reach the limit, so WDT_LIMIT counts RUN
  // cycles without a kick.
  always_comb begin
    wdt_fire = (state_q == StRun) && !wdt_kick && ((wdt_q + 1'b1) == WDT_LIMIT);
    wdt_d    = wdt_q + 1'b1;
    if ((state_q != StRun) || wdt_kick || wdt_fire) begin
      wdt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_wdt;
  assign wdt_fire   = 1'b0;
  assign unused_wdt = wdt_kick ^ (^WDT_LIMIT);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_sel_d  = pc_sel_q;
    expired_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (boot_req) begin
          state_d  = StRstHold;
          cnt_d    = CntW'(RST_HOLD_CYC - 1);
          pc_sel_d = pc_init_sel;
        end
      end
      StRstHold: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (core_unexcp_err) begin
          state_d = StHalt;
        end else if (wdt_fire) begin
          // Reboot keeps the previously captured pc_init_use.
          state_d   = StRstHold;
          cnt_d     = CntW'(RST_HOLD_CYC - 1);
          expired_d = 1'b1;
        end else if (core_wfi && !irq_lvl) begin
          state_d = StSleep;
        end
      end
      StSleep: begin
        // Core clock is stopped here, so its error flag is not trusted.
        if (irq_lvl) begin
          state_d = StWake;
          cnt_d   = CntW'(WAKE_SETTLE_CYC - 1);
        end
      end
      StWake: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHalt: begin
        if (err_clear) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with ctrl_state.
  always_comb begin
    rst_n_d   = (state_d == StRun) || (state_d == StSleep) || (state_d == StWake);
    clk_en_d  = (state_d != StSleep);
    ext_irq_d = (state_d == StRun) && irq_lvl;
    err_cnt_d = err_cnt_q;
    if ((state_d == StHalt) && (state_q != StHalt) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pc_sel_q  <= 1'b0;
      rst_n_q   <= 1'b0;
      clk_en_q  <= 1'b1;
      ext_irq_q <= 1'b0;
      expired_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_sel_q  <= pc_sel_d;
      rst_n_q   <= rst_n_d;
      clk_en_q  <= clk_en_d;
      ext_irq_q <= ext_irq_d;
      expired_q <= expired_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign core_rst_n       = rst_n_q;
  assign core_pc_init_use = pc_sel_q;
  assign core_ext_irq     = ext_irq_q;
  assign core_clk_en      = clk_en_q;
  assign ctrl_state       = state_q;
  assign err_count        = err_cnt_q;
  assign wdt_expired      = expired_q;

endmodule
